demux_sched: RTL and testbench

DEMUX_SCHED -- requirements
Module: demux_sched

---
 rtl/demux_sched_if.sv | 26 ++
 rtl/demux_sched.sv | 111 +++++++++++
 tb/tb_demux_sched.sv | 261 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/demux_sched_if.sv
// Handshake bundle between one producer, demux_sched and its N consumers.
// The producer/consumer side uses master; the scheduler uses slave.
interface demux_sched_if #(
    parameter int N = 8,
    parameter int W = 8
);
    logic [N-1:0] EN;
    logic [W-1:0] DIN;
    logic         DIN_VALID;
    logic         DIN_READY;
    logic [W-1:0] Y;
    logic [N-1:0] Y_VALID;
    logic [N-1:0] Y_READY;
    logic [2:0]   SEL;
    logic         BUSY;

    modport master (
        output EN, DIN, DIN_VALID, Y_READY,
        input  DIN_READY, Y, Y_VALID, SEL, BUSY
    );

    modport slave (
        input  EN, DIN, DIN_VALID, Y_READY,
        output DIN_READY, Y, Y_VALID, SEL, BUSY
    );
endinterface

// File: rtl/demux_sched.sv
// Burst demultiplexer: BURST beats per enabled channel, round-robin,
// through a one-entry output slot shared by all channels.
module demux_sched #(
    parameter int N     = 8,
    parameter int W     = 8,
    parameter int BURST = 4
) (
    input logic          CLK,
    input logic          RESET,
    demux_sched_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE,
        SEEK,
        SEND
    } state_t;

    localparam logic [3:0] BURST_C = 4'(BURST);

    state_t       state_q, state_d;
    logic [2:0]   sel_q, sel_d;
    logic [3:0]   acc_q, acc_d;
    logic         full_q, full_d;
    logic [W-1:0] y_q, y_d;

    logic         ch_en;
    logic         din_ready;
    logic         take;
    logic         give;
    logic         burst_done;
    logic [2:0]   seek_sel;
    logic [N-1:0] y_valid;

    assign ch_en = bus.EN[sel_q];

    // Descending scan so the nearest enabled channel at or above sel wins.
    always_comb begin
        seek_sel = sel_q;
        for (int i = N - 1; i >= 0; i--) begin
            if (bus.EN[3'(int'(sel_q) + i)]) begin
                seek_sel = 3'(int'(sel_q) + i);
            end
        end
    end

    always_comb begin
        din_ready  = (state_q == SEND) && ch_en
                  && (acc_q < BURST_C)
                  && (!full_q || bus.Y_READY[sel_q]);
        take       = bus.DIN_VALID && din_ready;
        give       = full_q && bus.Y_READY[sel_q];
        burst_done = (acc_q == BURST_C) || !ch_en;

        state_d = state_q;
        sel_d   = sel_q;
        acc_d   = acc_q;
        full_d  = take ? 1'b1 : (give ? 1'b0 : full_q);
        y_d     = take ? bus.DIN : y_q;

        unique case (state_q)
            IDLE: begin
                if (|bus.EN) state_d = SEEK;
            end
            SEEK: begin
                if (|bus.EN) begin
                    state_d = SEND;
                    sel_d   = seek_sel;
                end else begin
                    state_d = IDLE;
                end
            end
            SEND: begin
                acc_d = acc_q + 4'(take);
                // Leave only once the slot beat has gone to this channel.
                if (burst_done && !take && (!full_q || give)) begin
                    state_d = SEEK;
                    sel_d   = sel_q + 3'd1;
                    acc_d   = '0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q <= IDLE;
            sel_q   <= '0;
            acc_q   <= '0;
            full_q  <= 1'b0;
            y_q     <= '0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            acc_q   <= acc_d;
            full_q  <= full_d;
            y_q     <= y_d;
        end
    end

    always_comb begin
        y_valid        = '0;
        y_valid[sel_q] = full_q;
    end

    assign bus.DIN_READY = din_ready;
    assign bus.Y         = y_q;
    assign bus.Y_VALID   = y_valid;
    assign bus.SEL       = sel_q;
    assign bus.BUSY      = (state_q != IDLE);
endmodule

// File: tb/tb_demux_sched.sv
// Bench for demux_sched: cycle vector table plus scoreboarded streams.
// Outputs are sampled on the falling edge; inputs change just after rise.
module tb_demux_sched;
    localparam int N     = 8;
    localparam int W     = 8;
    localparam int BURST = 4;

    logic clk = 1'b0;
    logic rst;

    demux_sched_if #(.N(N), .W(W)) bus ();

    demux_sched #(.N(N), .W(W), .BURST(BURST)) dut (
        .CLK  (clk),
        .RESET(rst),
        .bus  (bus.slave)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]   ch;
        logic [W-1:0] data;
    } exp_t;

    typedef struct {
        logic         rst;
        logic [N-1:0] en;
        logic         dv;
        logic [W-1:0] din;
        logic [N-1:0] yr;
        logic         rdy;
        logic [N-1:0] yv;
        logic [W-1:0] y;
        logic [2:0]   sel;
        logic         busy;
    } vec_t;

    exp_t   sb[$];
    exp_t   mon_e;
    vec_t   tbl[$];
    int     n_cmp = 0;
    int     n_bad = 0;
    bit     mon_on = 1'b0;
    bit     pend = 1'b0;
    logic [W-1:0] pend_data;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)",
                     name, act, exp, $time);
        end
    endtask

    function automatic vec_t v(
        input logic r, input logic [7:0] en, input logic dv,
        input logic [7:0] din, input logic [7:0] yr, input logic rdy,
        input logic [7:0] yv, input logic [7:0] y, input logic [2:0] sel,
        input logic busy);
        vec_t t;
        t.rst = r;   t.en = en;   t.dv = dv;  t.din = din; t.yr = yr;
        t.rdy = rdy; t.yv = yv;   t.y = y;    t.sel = sel; t.busy = busy;
        return t;
    endfunction

    // Reference channel order: first enabled at or above 'from', wrapping.
    function automatic logic [2:0] first_en(input logic [2:0] from,
                                            input logic [N-1:0] en);
        for (int i = 0; i < N; i++) begin
            if (en[from + 3'(i)]) return from + 3'(i);
        end
        return from;
    endfunction

    always @(negedge clk) begin
        if (rst || !mon_on) begin
            pend = 1'b0;
        end else begin
            chk("onehot", 32'($onehot0(bus.Y_VALID)), 32'd1);
            if (pend) begin
                chk("lat_y", 32'(bus.Y), 32'(pend_data));
                chk("lat_vld", 32'(|bus.Y_VALID), 32'd1);
            end
            pend      = bus.DIN_VALID && bus.DIN_READY;
            pend_data = bus.DIN;
            if (|(bus.Y_VALID & bus.Y_READY)) begin
                if (sb.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL sb_empty: got Y=%0h, expected no output",
                             bus.Y);
                end else begin
                    mon_e = sb.pop_front();
                    chk("out_y", 32'(bus.Y), 32'(mon_e.data));
                    chk("out_vld", 32'(bus.Y_VALID), 32'(8'd1 << mon_e.ch));
                end
            end
        end
    end

    task automatic do_reset();
        rst           = 1'b1;
        bus.EN        = '0;
        bus.DIN       = '0;
        bus.DIN_VALID = 1'b0;
        bus.Y_READY   = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        sb.delete();
    endtask

    task automatic drive_beat(input logic [W-1:0] d, input logic [2:0] ch);
        bit ok = 1'b0;
        bus.DIN       = d;
        bus.DIN_VALID = 1'b1;
        for (int t = 0; t < 50 && !ok; t++) begin
            @(negedge clk);
            ok = bus.DIN_READY;
        end
        if (ok) begin
            sb.push_back('{ch, d});
        end else begin
            n_cmp++;
            n_bad++;
            $display("FAIL accept_timeout: beat %0h never accepted", d);
        end
        @(posedge clk);
        #1;
        bus.DIN_VALID = 1'b0;
    endtask

    task automatic drain();
        for (int t = 0; t < 40 && sb.size() != 0; t++) @(negedge clk);
        chk("drain", 32'(sb.size()), 32'd0);
        @(posedge clk);
        #1;
        mon_on = 1'b0;
    endtask

    task automatic stream(input logic [N-1:0] en, input int nb);
        logic [2:0] ch;
        do_reset();
        bus.EN      = en;
        bus.Y_READY = '1;
        mon_on      = 1'b1;
        ch = first_en(3'd0, en);
        for (int k = 1; k <= nb; k++) begin
            drive_beat(8'(k), ch);
            if (k % BURST == 0) ch = first_en(ch + 3'd1, en);
        end
        drain();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        tbl.push_back(v(0, 8'h01, 1, 8'hA1, 8'h00, 0, 8'h00, 8'h00, 0, 0));
        tbl.push_back(v(0, 8'h01, 1, 8'hA1, 8'h00, 0, 8'h00, 8'h00, 0, 1));
        tbl.push_back(v(0, 8'h01, 1, 8'hA1, 8'h00, 1, 8'h00, 8'h00, 0, 1));
        for (int i = 0; i < 5; i++)
            tbl.push_back(v(0, 8'h01, 1, 8'hA2, 8'h00, 0, 8'h01, 8'hA1, 0, 1));
        tbl.push_back(v(0, 8'h01, 1, 8'hA2, 8'h01, 1, 8'h01, 8'hA1, 0, 1));
        tbl.push_back(v(0, 8'h01, 1, 8'hA3, 8'h01, 1, 8'h01, 8'hA2, 0, 1));
        tbl.push_back(v(0, 8'h01, 1, 8'hA4, 8'h01, 1, 8'h01, 8'hA3, 0, 1));
        tbl.push_back(v(0, 8'h01, 1, 8'hA5, 8'h01, 0, 8'h01, 8'hA4, 0, 1));
        tbl.push_back(v(0, 8'h01, 1, 8'hA5, 8'h01, 0, 8'h00, 8'hA4, 1, 1));
        tbl.push_back(v(0, 8'h01, 1, 8'hA5, 8'h01, 1, 8'h00, 8'hA4, 0, 1));
        tbl.push_back(v(0, 8'h00, 0, 8'hA5, 8'h00, 0, 8'h01, 8'hA5, 0, 1));
        tbl.push_back(v(0, 8'h00, 0, 8'hA5, 8'h01, 0, 8'h01, 8'hA5, 0, 1));
        tbl.push_back(v(0, 8'h00, 0, 8'hA5, 8'h01, 0, 8'h00, 8'hA5, 1, 1));
        tbl.push_back(v(0, 8'h00, 0, 8'hA5, 8'h00, 0, 8'h00, 8'hA5, 1, 0));
        tbl.push_back(v(1, 8'h00, 0, 8'h00, 8'h00, 0, 8'h00, 8'hA5, 1, 0));
        tbl.push_back(v(0, 8'h00, 0, 8'h00, 8'h00, 0, 8'h00, 8'h00, 0, 0));

        do_reset();
        @(negedge clk);
        chk("rst_rdy", 32'(bus.DIN_READY), 32'd0);
        chk("rst_vld", 32'(bus.Y_VALID), 32'd0);
        chk("rst_busy", 32'(bus.BUSY), 32'd0);
        chk("rst_sel", 32'(bus.SEL), 32'd0);
        chk("rst_y", 32'(bus.Y), 32'd0);

        bus.DIN_VALID = 1'b1;
        bus.Y_READY   = '1;
        repeat (10) begin
            @(negedge clk);
            chk("noen_rdy", 32'(bus.DIN_READY), 32'd0);
            chk("noen_vld", 32'(bus.Y_VALID), 32'd0);
            chk("noen_busy", 32'(bus.BUSY), 32'd0);
        end

        do_reset();
        for (int r = 0; r < tbl.size(); r++) begin
            rst           = tbl[r].rst;
            bus.EN        = tbl[r].en;
            bus.DIN_VALID = tbl[r].dv;
            bus.DIN       = tbl[r].din;
            bus.Y_READY   = tbl[r].yr;
            @(negedge clk);
            chk($sformatf("vec%0d_rdy", r), 32'(bus.DIN_READY), 32'(tbl[r].rdy));
            chk($sformatf("vec%0d_vld", r), 32'(bus.Y_VALID), 32'(tbl[r].yv));
            chk($sformatf("vec%0d_y", r), 32'(bus.Y), 32'(tbl[r].y));
            chk($sformatf("vec%0d_sel", r), 32'(bus.SEL), 32'(tbl[r].sel));
            chk($sformatf("vec%0d_busy", r), 32'(bus.BUSY), 32'(tbl[r].busy));
            @(posedge clk);
            #1;
        end

        stream(8'hFF, 32);
        stream(8'b1000_0100, 24);

        // Drop the active channel's enable mid-burst.
        do_reset();
        mon_on      = 1'b1;
        bus.Y_READY = '1;
        bus.EN      = 8'b0100_1000;
        drive_beat(8'h31, 3'd3);
        drive_beat(8'h32, 3'd3);
        bus.EN = 8'b0100_0000;
        @(negedge clk);
        chk("drop_rdy", 32'(bus.DIN_READY), 32'd0);
        chk("drop_sel", 32'(bus.SEL), 32'd3);
        @(posedge clk);
        #1;
        for (int k = 0; k < BURST; k++) drive_beat(8'(8'h61 + k), 3'd6);
        drain();

        // Reset while the slot holds a beat for channel 5.
        do_reset();
        mon_on      = 1'b1;
        bus.EN      = 8'h20;
        bus.Y_READY = '0;
        drive_beat(8'h55, 3'd5);
        @(negedge clk);
        chk("hold_vld", 32'(bus.Y_VALID), 32'h20);
        chk("hold_sel", 32'(bus.SEL), 32'd5);
        rst = 1'b1;
        @(negedge clk);
        chk("mrst_vld", 32'(bus.Y_VALID), 32'd0);
        chk("mrst_sel", 32'(bus.SEL), 32'd0);
        chk("mrst_busy", 32'(bus.BUSY), 32'd0);
        chk("mrst_rdy", 32'(bus.DIN_READY), 32'd0);
        chk("mrst_y", 32'(bus.Y), 32'd0);
        rst    = 1'b0;
        mon_on = 1'b0;
        sb.delete();
        @(posedge clk);
        #1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
